// File: rtl/stream_min_max_pkg.sv
// stream_min_max_pkg
//   Shared definitions for the stream_min_max statistics stage:
//   - frame state encoding (EMPTY / ACCUM / HOLD)
//   - saturating increment helper used by the sample and zero counters
package stream_min_max_pkg;

  localparam logic [1:0] EMPTY = 2'd0;  // no sample of the current frame seen yet
  localparam logic [1:0] ACCUM = 2'd1;  // frame in progress
  localparam logic [1:0] HOLD  = 2'd2;  // frame result presented downstream

  // Saturating increment on a 32-bit carrier; callers zero-extend their
  // counter and truncate the result back. limit is the all-ones value of
  // the caller's counter width, so counters up to 32 bits are supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    logic [31:0] result;
    if (value == limit) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

  // True when an increment of value would be clipped at limit.
  function automatic logic at_limit(input logic [31:0] value,
                                    input logic [31:0] limit);
    return (value == limit);
  endfunction

endpackage

// File: rtl/cmp_zelg.sv
// CmpZelg
//   Unsigned magnitude comparator producing zero / less / greater flags.
//   Ports:
//     iv_x, iv_y  in   p_WIDTH  operands
//     o_less      out  1        x < y
//     o_greater   out  1        x > y
//     o_zero      out  1        operands are zero; only meaningful when x == y
module CmpZelg #(
  parameter int p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] iv_x,
  input  logic [p_WIDTH-1:0] iv_y,
  output logic               o_less,
  output logic               o_greater,
  output logic               o_zero
);

  // Purely combinational compare; o_zero looks at the common bits only,
  // so it reports "both zero" correctly only when the operands match.
  always_comb begin
    o_less    = (iv_x < iv_y);
    o_greater = (iv_x > iv_y);
    o_zero    = ~|(iv_x & iv_y);
  end

endmodule

// File: rtl/stream_min_max.sv
// stream_min_max
//   Framed streaming statistics: running min, max, sample count and
//   zero-sample count. On the last sample of a frame the result is held on
//   a valid/ready output until accepted.
//   Ports:
//     i_clk, i_reset        clock, synchronous active-high reset
//     iv_data/i_valid/i_last/o_ready   sample input handshake
//     ov_min/ov_max         frame minimum / maximum
//     ov_count              samples in frame (saturating)
//     ov_zero_count         zero-valued samples (saturating)
//     o_overflow            a counter saturated during this frame
//     o_valid/i_ready       result output handshake
module stream_min_max
  import stream_min_max_pkg::*;
#(
  parameter int p_WIDTH     = 8,
  parameter int p_CNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [p_WIDTH-1:0]     iv_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [p_WIDTH-1:0]     ov_min,
  output logic [p_WIDTH-1:0]     ov_max,
  output logic [p_CNT_WIDTH-1:0] ov_count,
  output logic [p_CNT_WIDTH-1:0] ov_zero_count,
  output logic                   o_overflow,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << p_CNT_WIDTH) - 64'd1);

  logic [1:0]             state;
  logic                   min_less;
  logic                   max_greater;
  logic                   is_zero;
  logic [p_CNT_WIDTH-1:0] count_inc;
  logic [p_CNT_WIDTH-1:0] zero_inc;
  logic                   count_sat;
  logic                   zero_sat;

  // Flags from the comparators that this stage has no use for.
  logic min_greater_unused;
  logic min_zero_unused;
  logic max_less_unused;
  logic max_zero_unused;

  CmpZelg #(.p_WIDTH(p_WIDTH)) u_cmp_min (
    .iv_x      (iv_data),
    .iv_y      (ov_min),
    .o_less    (min_less),
    .o_greater (min_greater_unused),
    .o_zero    (min_zero_unused)
  );

  CmpZelg #(.p_WIDTH(p_WIDTH)) u_cmp_max (
    .iv_x      (iv_data),
    .iv_y      (ov_max),
    .o_less    (max_less_unused),
    .o_greater (max_greater),
    .o_zero    (max_zero_unused)
  );

  // Zero detect and saturating counter next values.
  always_comb begin
    is_zero   = ~|iv_data;
    count_inc = p_CNT_WIDTH'(sat_inc(32'(ov_count), CNT_MAX));
    zero_inc  = p_CNT_WIDTH'(sat_inc(32'(ov_zero_count), CNT_MAX));
    count_sat = at_limit(32'(ov_count), CNT_MAX);
    zero_sat  = at_limit(32'(ov_zero_count), CNT_MAX);
  end

  // Frame state machine and statistics registers. o_ready / o_valid are
  // registered alongside the state so they decode it without glue logic.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= EMPTY;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      ov_min        <= '0;
      ov_max        <= '0;
      ov_count      <= '0;
      ov_zero_count <= '0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          // o_ready is 1 here, so i_valid alone is a transfer.
          if (i_valid) begin
            ov_min        <= iv_data;
            ov_max        <= iv_data;
            ov_count      <= p_CNT_WIDTH'(1);
            ov_zero_count <= {{(p_CNT_WIDTH-1){1'b0}}, is_zero};
            state         <= i_last ? HOLD : ACCUM;
            o_valid       <= i_last;
            o_ready       <= ~i_last;
          end
        end
        ACCUM: begin
          if (i_valid) begin
            if (min_less) begin
              ov_min <= iv_data;
            end
            if (max_greater) begin
              ov_max <= iv_data;
            end
            ov_count <= count_inc;
            if (is_zero) begin
              ov_zero_count <= zero_inc;
            end
            // Sticky until the result is handed off.
            o_overflow <= o_overflow | count_sat | (is_zero & zero_sat);
            state      <= i_last ? HOLD : ACCUM;
            o_valid    <= i_last;
            o_ready    <= ~i_last;
          end
        end
        HOLD: begin
          // No bypass: a new sample is only taken once back in EMPTY.
          if (i_ready) begin
            state         <= EMPTY;
            o_valid       <= 1'b0;
            o_ready       <= 1'b1;
            ov_min        <= '0;
            ov_max        <= '0;
            ov_count      <= '0;
            ov_zero_count <= '0;
            o_overflow    <= 1'b0;
          end
        end
        default: begin
          state         <= EMPTY;
          o_valid       <= 1'b0;
          o_ready       <= 1'b1;
          ov_min        <= '0;
          ov_max        <= '0;
          ov_count      <= '0;
          ov_zero_count <= '0;
          o_overflow    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_min_max.sv
// tb_stream_min_max
//   Directed bench for stream_min_max. Two instances: default counter
//   width, and a 2-bit counter instance for saturation. Expected frame
//   results are queued when a frame is driven and popped on output.
module tb_stream_min_max;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] iv_data;
  logic       i_valid;
  logic       i_last;
  logic       i_ready;
  logic       sat_sel;

  logic        ready_a, valid_a, ovf_a;
  logic [7:0]  min_a, max_a;
  logic [15:0] cnt_a, zc_a;
  logic        ready_b, valid_b, ovf_b;
  logic [7:0]  min_b, max_b;
  logic [1:0]  cnt_b, zc_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [15:0] cnt;
    logic [15:0] zc;
    logic        ovf;
  } res_t;
  res_t sb[$];

  always #5 clk = ~clk;

  stream_min_max #(.p_WIDTH(8), .p_CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .iv_data(iv_data),
    .i_valid(i_valid & ~sat_sel), .i_last(i_last), .o_ready(ready_a),
    .ov_min(min_a), .ov_max(max_a), .ov_count(cnt_a), .ov_zero_count(zc_a),
    .o_overflow(ovf_a), .o_valid(valid_a), .i_ready(i_ready)
  );

  stream_min_max #(.p_WIDTH(8), .p_CNT_WIDTH(2)) dut_sat (
    .i_clk(clk), .i_reset(i_reset), .iv_data(iv_data),
    .i_valid(i_valid & sat_sel), .i_last(i_last), .o_ready(ready_b),
    .ov_min(min_b), .ov_max(max_b), .ov_count(cnt_b), .ov_zero_count(zc_b),
    .o_overflow(ovf_b), .o_valid(valid_b), .i_ready(i_ready)
  );

  logic        cur_ready, cur_valid, cur_ovf;
  logic [7:0]  cur_min, cur_max;
  logic [15:0] cur_cnt, cur_zc;
  assign cur_ready = sat_sel ? ready_b : ready_a;
  assign cur_valid = sat_sel ? valid_b : valid_a;
  assign cur_ovf   = sat_sel ? ovf_b   : ovf_a;
  assign cur_min   = sat_sel ? min_b   : min_a;
  assign cur_max   = sat_sel ? max_b   : max_a;
  assign cur_cnt   = sat_sel ? {14'd0, cnt_b} : cnt_a;
  assign cur_zc    = sat_sel ? {14'd0, zc_b}  : zc_a;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] mn, input logic [7:0] mx,
                      input logic [15:0] cnt, input logic [15:0] zc, input logic ovf);
    res_t r;
    r.mn = mn; r.mx = mx; r.cnt = cnt; r.zc = zc; r.ovf = ovf;
    sb.push_back(r);
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    i_valid = 1'b1;
    iv_data = d;
    i_last  = last;
    while (!cur_ready && n < 20) begin
      tick;
      n++;
    end
    check("send_ready", {31'd0, cur_ready}, 32'd1);
    tick;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Result must be valid right after the last-sample edge; i_ready is 1.
  task automatic check_result(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, {31'd0, cur_valid}, 32'd1);
      check({tag, "_ready"}, {31'd0, cur_ready}, 32'd0);
      check({tag, "_min"},   {24'd0, cur_min}, {24'd0, e.mn});
      check({tag, "_max"},   {24'd0, cur_max}, {24'd0, e.mx});
      check({tag, "_count"}, {16'd0, cur_cnt}, {16'd0, e.cnt});
      check({tag, "_zero"},  {16'd0, cur_zc},  {16'd0, e.zc});
      check({tag, "_ovf"},   {31'd0, cur_ovf}, {31'd0, e.ovf});
      tick;
      check({tag, "_after_valid"}, {31'd0, cur_valid}, 32'd0);
      check({tag, "_after_ready"}, {31'd0, cur_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [7:0]  hold_min;
    logic [15:0] hold_cnt;
    i_reset = 1'b1; iv_data = 8'd0; i_valid = 1'b0; i_last = 1'b0;
    i_ready = 1'b1; sat_sel = 1'b0;
    tick; tick;
    i_reset = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_min",   {24'd0, min_a}, 32'd0);
    check("rst_max",   {24'd0, max_a}, 32'd0);
    check("rst_count", {16'd0, cnt_a}, 32'd0);
    check("rst_zero",  {16'd0, zc_a},  32'd0);
    check("rst_ovf",   {31'd0, ovf_a}, 32'd0);

    // Basic frame
    push(8'd3, 8'd9, 16'd4, 16'd0, 1'b0);
    send(8'd5, 1'b0); send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd3, 1'b1);
    check_result("basic");

    // Single-sample frames
    push(8'd0, 8'd0, 16'd1, 16'd1, 1'b0);
    send(8'h00, 1'b1);
    check_result("single0");
    push(8'hFF, 8'hFF, 16'd1, 16'd0, 1'b0);
    send(8'hFF, 1'b1);
    check_result("singleFF");

    // Backpressure: result held, offered sample not consumed
    i_ready = 1'b0;
    push(8'd1, 8'd1, 16'd1, 16'd0, 1'b0);
    send(8'd1, 1'b1);
    hold_min = min_a;
    hold_cnt = cnt_a;
    i_valid = 1'b1; iv_data = 8'h11; i_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", {31'd0, valid_a}, 32'd1);
      check("bp_ready", {31'd0, ready_a}, 32'd0);
      check("bp_min",   {24'd0, min_a}, {24'd0, hold_min});
      check("bp_count", {16'd0, cnt_a}, {16'd0, hold_cnt});
    end
    i_valid = 1'b0; i_last = 1'b0;
    i_ready = 1'b1;
    check_result("bp_frame");
    check("bp_cleared_count", {16'd0, cnt_a}, 32'd0);
    push(8'd7, 8'd7, 16'd2, 16'd0, 1'b0);
    send(8'd7, 1'b0); send(8'd7, 1'b1);
    check_result("bp_next");

    // Gapped input
    push(8'd0, 8'd255, 16'd4, 16'd1, 1'b0);
    send(8'd200, 1'b0); tick; tick;
    send(8'd17, 1'b0);  tick;
    send(8'd0, 1'b0);   tick; tick; tick;
    send(8'd255, 1'b1);
    check_result("gapped");

    // Saturation on the 2-bit counter instance
    sat_sel = 1'b1;
    push(8'd0, 8'd0, 16'd3, 16'd3, 1'b1);
    for (int i = 0; i < 4; i++) send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    check_result("sat");
    push(8'd2, 8'd2, 16'd1, 16'd0, 1'b0);
    send(8'd2, 1'b1);
    check_result("sat_next");
    sat_sel = 1'b0;

    // Reset mid-frame discards the frame
    send(8'd4, 1'b0); send(8'd8, 1'b0);
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    check("midrst_valid", {31'd0, valid_a}, 32'd0);
    check("midrst_ready", {31'd0, ready_a}, 32'd1);
    check("midrst_count", {16'd0, cnt_a}, 32'd0);
    tick;
    check("midrst_no_result", {31'd0, valid_a}, 32'd0);
    push(8'd6, 8'd6, 16'd1, 16'd0, 1'b0);
    send(8'd6, 1'b1);
    check_result("midrst");

    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_min_max.md
Name: stream_min_max

Overview:
- Streaming statistics stage that sits directly downstream of the CmpZelg comparator. It instantiates CmpZelg and consumes its flags.
- Accepts a framed sample stream over a valid/ready handshake and tracks the running minimum, running maximum, sample count and zero-sample count.
- On the last sample of a frame, it presents the frame result on a valid/ready output port.
- Its consumers are frame-level range checks and histogram set-up logic.

Parameters:
- p_WIDTH, 8, sample width in bits (≥1).
- p_CNT_WIDTH, 16, width of the sample and zero counters (≥2).

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- iv_data  in  p_WIDTH  unsigned sample.
- i_valid  in  1  sample valid.
- i_last  in  1  marks the final sample of a frame; qualified by i_valid.
- o_ready  out  1  stage can accept a sample.
- ov_min  out  p_WIDTH  frame minimum.
- ov_max  out  p_WIDTH  frame maximum.
- ov_count  out  p_CNT_WIDTH  samples in frame (saturating).
- ov_zero_count  out  p_CNT_WIDTH  samples equal to 0 (saturating).
- o_overflow  out  1  either counter saturated during this frame.
- o_valid  out  1  frame result valid.
- i_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (i_reset=1 at an edge):
  - State goes to EMPTY.
  - o_valid=0, o_ready=1.
  - ov_min, ov_max, ov_count, ov_zero_count = 0; o_overflow=0.
  - Reset mid-frame or while in HOLD discards the frame entirely. No result is emitted.
- Handshakes:
  - Input transfer: i_valid & o_ready at an edge.
  - Output transfer: o_valid & i_ready at an edge.
  - o_ready is 1 exactly in EMPTY and ACCUM, and 0 in HOLD.
  - o_valid is 1 exactly in HOLD.
  - No same-cycle bypass from HOLD to a new input.
- States:
  - EMPTY: no sample yet in the frame.
    - On input transfer: min=max=iv_data; count=1; zero_count=(iv_data==0).
    - Next state is HOLD if i_last, else ACCUM.
  - ACCUM: on input transfer:
    - min←iv_data if CmpZelg(x=iv_data, y=min).o_less.
    - max←iv_data if CmpZelg(x=iv_data, y=max).o_greater.
    - Equal values leave min and max unchanged.
    - count+1; zero_count+1 if iv_data==0.
    - Next state is HOLD if i_last, else stay in ACCUM.
    - With no transfer, all registers hold.
  - HOLD: all outputs are stable and unchanged while i_ready=0.
    - On output transfer: go to EMPTY; clear all stats and o_overflow. The cleared values are visible in the next cycle.
- Counter rules:
  - Counters saturate at 2^p_CNT_WIDTH−1 and never wrap.
  - An increment attempted at saturation sets o_overflow, which is sticky until the output transfer.
- Zero detection uses the NOR-reduction of iv_data, not the comparator o_zero flag. That flag is only meaningful when x==y.
- Latency:
  - Result valid (o_valid=1) in the cycle after the edge that accepts the i_last sample.
  - Result accepted in the same cycle i_ready is high.
  - Minimum frame-to-frame throughput is one idle input cycle per frame (the HOLD cycle).
- The comparator path is purely combinational from the registered min/max and iv_data. The stage adds no pipeline register.
- ov_* values outside HOLD reflect the running stats and are not guaranteed to be meaningful to consumers.

Decomposition:
- Shared package: the state encoding constants (EMPTY=2'd0, ACCUM=2'd1, HOLD=2'd2) and a saturating-increment helper function for the counters.
- Sub-module: two instances of the existing CmpZelg (p_WIDTH=p_WIDTH), one for the min comparison and one for the max comparison. No new sub-module is needed.

Test Plan:
- Basic frame: p_WIDTH=8; samples 5,3,9,3(last); i_ready=1 → one cycle after the last accept, o_valid=1 with min=3, max=9, count=4, zero_count=0, o_overflow=0. In the following cycle o_valid=0 and o_ready=1.
- Single-sample frame: 0x00 with i_last → min=max=0, count=1, zero_count=1. Repeat with 0xFF → min=max=255.
- Backpressure:
  - Hold i_ready=0 for 5 cycles in HOLD → outputs constant and o_ready=0. Samples presented then are not accepted; the bench checks they are not consumed.
  - Release i_ready → EMPTY next cycle. The next frame 7,7(last) yields min=max=7.
- Gapped input: samples 200, 17, 0, 255(last) with i_valid deasserted between them → min=0, max=255, count=4, zero_count=1.
- Saturation: p_CNT_WIDTH=2; frame of 5 zeros → count=3, zero_count=3, o_overflow=1. The next frame gives o_overflow=0.
- Reset mid-frame: accept 4,8, assert i_reset for one cycle, then send 6(last) → result min=max=6, count=1. No result is emitted for the aborted frame.
